// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register in front of the ALU. Resolves operand forwarding
// at capture time, builds the B operand and inserts load-use bubbles.
module alu_operand_stage #(
   parameter int DP_WIDTH  = 32,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [5:0]           id_op_code,
   input  logic [5:0]           id_func_code,
   input  logic [4:0]           id_shamt,
   input  logic [4:0]           id_rs,
   input  logic [4:0]           id_rt,
   input  logic [4:0]           id_rd,
   input  logic [DP_WIDTH-1:0]  id_rs_data,
   input  logic [DP_WIDTH-1:0]  id_rt_data,
   input  logic [15:0]          id_imm,
   input  logic [1:0]           id_imm_mode,
   input  logic                 id_uses_rs,
   input  logic                 id_uses_rt,
   input  logic                 id_reg_write,
   input  logic                 id_mem_read,
   input  logic                 id_mem_write,
   input  logic [DP_WIDTH-1:0]  ex_alu_result,
   input  logic                 mem_reg_write,
   input  logic [4:0]           mem_rd,
   input  logic [DP_WIDTH-1:0]  mem_data,
   input  logic                 wb_reg_write,
   input  logic [4:0]           wb_rd,
   input  logic [DP_WIDTH-1:0]  wb_data,
   input  logic                 flush,
   input  logic                 hold,
   output logic                 stall_id,
   output logic                 ex_valid,
   output logic [DP_WIDTH-1:0]  ex_a,
   output logic [DP_WIDTH-1:0]  ex_b,
   output logic [DP_WIDTH-1:0]  ex_store_data,
   output logic [4:0]           ex_shamt,
   output logic [5:0]           ex_op_code,
   output logic [5:0]           ex_func_code,
   output logic [4:0]           ex_rd,
   output logic                 ex_reg_write,
   output logic                 ex_mem_read,
   output logic                 ex_mem_write,
   output logic [CNT_WIDTH-1:0] stall_count
);

   localparam int EXT_W = DP_WIDTH - 16;

   logic                ex_fwd_en;
   logic [DP_WIDTH-1:0] rs_fwd;
   logic [DP_WIDTH-1:0] rt_fwd;
   logic [DP_WIDTH-1:0] b_next;
   logic                hazard;

   // Priority EX > MEM > WB > register file; r0 is never forwarded.
   function automatic logic [DP_WIDTH-1:0] fwd_sel(
      input logic [4:0]          idx,
      input logic [DP_WIDTH-1:0] rf_val,
      input logic                ex_en,
      input logic [4:0]          ex_idx,
      input logic [DP_WIDTH-1:0] ex_val,
      input logic                mem_en,
      input logic [4:0]          mem_idx,
      input logic [DP_WIDTH-1:0] mem_val,
      input logic                wb_en,
      input logic [4:0]          wb_idx,
      input logic [DP_WIDTH-1:0] wb_val
   );
      logic [DP_WIDTH-1:0] res;
      res = rf_val;
      if (idx != 5'd0) begin
         if (ex_en && (ex_idx == idx))
            res = ex_val;
         else if (mem_en && (mem_idx == idx))
            res = mem_val;
         else if (wb_en && (wb_idx == idx))
            res = wb_val;
      end
      return res;
   endfunction

   // A load in EX has no result yet, so it is excluded from EX forwarding.
   assign ex_fwd_en = ex_valid & ex_reg_write & ~ex_mem_read;

   always_comb begin
      rs_fwd = fwd_sel(id_rs, id_rs_data, ex_fwd_en, ex_rd, ex_alu_result,
                       mem_reg_write, mem_rd, mem_data,
                       wb_reg_write, wb_rd, wb_data);
      rt_fwd = fwd_sel(id_rt, id_rt_data, ex_fwd_en, ex_rd, ex_alu_result,
                       mem_reg_write, mem_rd, mem_data,
                       wb_reg_write, wb_rd, wb_data);
   end

   always_comb begin
      b_next = rt_fwd;
      case (id_imm_mode)
         2'b01:   b_next = {{EXT_W{id_imm[15]}}, id_imm};
         2'b10:   b_next = {{EXT_W{1'b0}}, id_imm};
         2'b11:   b_next = {id_imm, {EXT_W{1'b0}}};
         default: b_next = rt_fwd;
      endcase
   end

   assign hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
                   ((id_uses_rs & (ex_rd == id_rs)) |
                    (id_uses_rt & (ex_rd == id_rt)));

   assign stall_id = hazard | hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid      <= 1'b0;
         ex_a          <= '0;
         ex_b          <= '0;
         ex_store_data <= '0;
         ex_shamt      <= '0;
         ex_op_code    <= '0;
         ex_func_code  <= '0;
         ex_rd         <= '0;
         ex_reg_write  <= 1'b0;
         ex_mem_read   <= 1'b0;
         ex_mem_write  <= 1'b0;
         stall_count   <= '0;
      end else if (!hold) begin
         // Data fields load on every non-held cycle; they only matter when valid.
         ex_a          <= rs_fwd;
         ex_b          <= b_next;
         ex_store_data <= rt_fwd;
         ex_shamt      <= id_shamt;
         ex_op_code    <= id_op_code;
         ex_func_code  <= id_func_code;
         ex_rd         <= id_rd;
         if (flush || hazard) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
         end else begin
            ex_valid     <= id_valid;
            ex_reg_write <= id_reg_write & id_valid;
            ex_mem_read  <= id_mem_read & id_valid;
            ex_mem_write <= id_mem_write & id_valid;
         end
         if (!flush && hazard && (stall_count != {CNT_WIDTH{1'b1}}))
            stall_count <= stall_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: immediates, forwarding priority,
// load-use bubble, flush/hold and stall counter saturation.
module tb_alu_operand_stage;

   // Narrow counter keeps the saturation run short (one bubble every 2 cycles).
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid;
   logic [5:0]    id_op_code, id_func_code;
   logic [4:0]    id_shamt, id_rs, id_rt, id_rd;
   logic [31:0]   id_rs_data, id_rt_data;
   logic [15:0]   id_imm;
   logic [1:0]    id_imm_mode;
   logic          id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, id_mem_write;
   logic [31:0]   ex_alu_result;
   logic          mem_reg_write, wb_reg_write;
   logic [4:0]    mem_rd, wb_rd;
   logic [31:0]   mem_data, wb_data;
   logic          flush, hold;
   logic          stall_id, ex_valid;
   logic [31:0]   ex_a, ex_b, ex_store_data;
   logic [4:0]    ex_shamt, ex_rd;
   logic [5:0]    ex_op_code, ex_func_code;
   logic          ex_reg_write, ex_mem_read, ex_mem_write;
   logic [CW-1:0] stall_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   alu_operand_stage #(.DP_WIDTH(32), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_op_code(id_op_code),
      .id_func_code(id_func_code), .id_shamt(id_shamt), .id_rs(id_rs),
      .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm(id_imm), .id_imm_mode(id_imm_mode),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .ex_alu_result(ex_alu_result),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_data(mem_data),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .flush(flush), .hold(hold), .stall_id(stall_id), .ex_valid(ex_valid),
      .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
      .ex_shamt(ex_shamt), .ex_op_code(ex_op_code), .ex_func_code(ex_func_code),
      .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .stall_count(stall_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic [4:0] rs, input logic [31:0] rs_d,
                            input logic [4:0] rt, input logic [31:0] rt_d,
                            input logic [4:0] rd, input logic [15:0] imm,
                            input logic [1:0] mode, input logic u_rs,
                            input logic u_rt, input logic rw, input logic mr);
      id_valid     = 1'b1;
      id_rs        = rs;  id_rs_data = rs_d;
      id_rt        = rt;  id_rt_data = rt_d;
      id_rd        = rd;  id_imm     = imm;
      id_imm_mode  = mode;
      id_uses_rs   = u_rs; id_uses_rt = u_rt;
      id_reg_write = rw;   id_mem_read = mr;
      id_mem_write = 1'b0;
      id_op_code   = mr ? 6'h23 : 6'h00;
      id_func_code = 6'h20;
   endtask

   initial begin
      rst = 1'b1;
      id_valid = 0; id_op_code = 0; id_func_code = 0; id_shamt = 0;
      id_rs = 0; id_rt = 0; id_rd = 0; id_rs_data = 0; id_rt_data = 0;
      id_imm = 0; id_imm_mode = 0; id_uses_rs = 0; id_uses_rt = 0;
      id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
      ex_alu_result = 0; mem_reg_write = 0; mem_rd = 0; mem_data = 0;
      wb_reg_write = 0; wb_rd = 0; wb_data = 0; flush = 0; hold = 0;
      step(); step();
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_a", ex_a, 32'd0);
      check("rst_b", ex_b, 32'd0);
      check("rst_cnt", {24'd0, stall_count}, 32'd0);
      check("rst_stall_id", {31'd0, stall_id}, 32'd0);
      rst = 1'b0;

      // Immediate modes (addi r4 <- r3 + imm)
      set_instr(5'd3, 32'h10, 5'd4, 32'h99, 5'd4, 16'hFFFF, 2'b01, 1, 0, 1, 0);
      id_shamt = 5'd9;
      step();
      check("addi_valid", {31'd0, ex_valid}, 32'd1);
      check("addi_a", ex_a, 32'h10);
      check("imm_sext", ex_b, 32'hFFFF_FFFF);
      check("addi_store", ex_store_data, 32'h99);
      check("addi_shamt", {27'd0, ex_shamt}, 32'd9);
      id_imm_mode = 2'b10;
      step();
      check("imm_zext", ex_b, 32'h0000_FFFF);
      id_imm_mode = 2'b11;
      step();
      check("imm_upper", ex_b, 32'hFFFF_0000);

      // Forwarding priority on r5
      set_instr(5'd1, 32'h1, 5'd2, 32'h2, 5'd5, 16'h0, 2'b00, 1, 1, 1, 0);
      step();
      ex_alu_result = 32'hAAAA;
      mem_reg_write = 1; mem_rd = 5'd5; mem_data = 32'hBBBB;
      wb_reg_write  = 1; wb_rd  = 5'd5; wb_data  = 32'hCCCC;
      set_instr(5'd5, 32'hDDDD, 5'd2, 32'h2, 5'd6, 16'h0, 2'b00, 1, 1, 1, 0);
      step();
      check("fwd_ex", ex_a, 32'hAAAA);
      step();
      check("fwd_mem", ex_a, 32'hBBBB);
      mem_reg_write = 0;
      step();
      check("fwd_wb", ex_a, 32'hCCCC);
      wb_reg_write = 0;
      step();
      check("fwd_rf", ex_a, 32'hDDDD);
      set_instr(5'd5, 32'hDDDD, 5'd2, 32'h2, 5'd0, 16'h0, 2'b00, 1, 1, 1, 0);
      step();
      mem_reg_write = 1; mem_rd = 5'd0; wb_reg_write = 1; wb_rd = 5'd0;
      set_instr(5'd0, 32'h0, 5'd2, 32'h2, 5'd9, 16'h0, 2'b00, 1, 1, 1, 0);
      step();
      check("fwd_r0", ex_a, 32'h0);
      mem_reg_write = 0; wb_reg_write = 0;

      // Load-use: lw r7 then add r8,r7,r2
      set_instr(5'd1, 32'h100, 5'd7, 32'h0, 5'd7, 16'h4, 2'b01, 1, 0, 1, 1);
      step();
      set_instr(5'd7, 32'h5555, 5'd2, 32'h22, 5'd8, 16'h0, 2'b00, 1, 1, 1, 0);
      #1;
      check("lu_stall_id", {31'd0, stall_id}, 32'd1);
      step();
      check("lu_bubble", {31'd0, ex_valid}, 32'd0);
      check("lu_bubble_rw", {31'd0, ex_reg_write}, 32'd0);
      check("lu_cnt", {24'd0, stall_count}, 32'd1);
      check("lu_stall_rel", {31'd0, stall_id}, 32'd0);
      mem_reg_write = 1; mem_rd = 5'd7; mem_data = 32'h1234;
      step();
      check("lu_valid", {31'd0, ex_valid}, 32'd1);
      check("lu_a_mem", ex_a, 32'h1234);
      check("lu_b", ex_b, 32'h22);
      mem_reg_write = 0;

      // flush + hold: stage frozen
      set_instr(5'd1, 32'h77, 5'd2, 32'h88, 5'd9, 16'h0, 2'b00, 1, 1, 1, 0);
      flush = 1; hold = 1;
      #1;
      check("hold_stall_id", {31'd0, stall_id}, 32'd1);
      step();
      check("hold_valid", {31'd0, ex_valid}, 32'd1);
      check("hold_rd", {27'd0, ex_rd}, 32'd8);
      check("hold_a", ex_a, 32'h1234);
      hold = 0;
      step();
      check("flush_valid", {31'd0, ex_valid}, 32'd0);
      check("flush_rw", {31'd0, ex_reg_write}, 32'd0);
      flush = 0;

      // Hold during a hazard does not count
      set_instr(5'd1, 32'h100, 5'd7, 32'h0, 5'd7, 16'h4, 2'b01, 1, 0, 1, 1);
      step();
      set_instr(5'd7, 32'h5555, 5'd2, 32'h22, 5'd8, 16'h0, 2'b00, 1, 1, 1, 0);
      hold = 1;
      step();
      check("hold_hz_cnt", {24'd0, stall_count}, 32'd1);
      check("hold_hz_mr", {31'd0, ex_mem_read}, 32'd1);
      hold = 0;
      step();
      check("hz_cnt2", {24'd0, stall_count}, 32'd2);

      // Saturation: 2^CW+3 further bubbles
      for (int i = 0; i < (1 << CW) + 3; i++) begin
         set_instr(5'd1, 32'h100, 5'd7, 32'h0, 5'd7, 16'h4, 2'b01, 1, 0, 1, 1);
         step();
         set_instr(5'd7, 32'h5555, 5'd2, 32'h22, 5'd8, 16'h0, 2'b00, 1, 1, 1, 0);
         step();
      end
      check("cnt_sat", {24'd0, stall_count}, 32'h0000_00FF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
